// File: rtl/mult_par_pkg.sv
// Shared types and helpers for the parity-protected sequential multiplier.
package mult_par_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Zero-extension does not change parity, so callers widen to 64 bits.
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned (WIDTH+1) x (WIDTH+1) shift-add multiplier, one multiplier bit per cycle.
// done/product are combinational on the final step so the caller can register them.
module seq_mult_core
  import mult_par_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH:0]     mcand_in,
  input  logic [WIDTH:0]     mplier_in,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  // |b| <= 2^(WIDTH-1), so WIDTH steps cover every set bit of the multiplier.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    done     = busy && (cnt == CW'(WIDTH - 1));
    product  = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{(WIDTH-1){1'b0}}, mcand_in};
      mplier <= mplier_in;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_par_responder.sv
// Responder side of the req/ack/result_rdy multiply interface: parity check,
// sign-magnitude handling around seq_mult_core, and registered handshake outputs.
module mult_par_responder
  import mult_par_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter bit          CHECK_PARITY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   arg_a,
  input  logic               arg_a_parity,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_b_parity,
  input  logic               req,
  output logic               ack,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               result_rdy,
  output logic               arg_parity_error
);

  state_t             state;
  logic               neg_q;
  logic               err_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;
  logic               arg_err;
  logic               start;
  logic               core_done;
  logic [2*WIDTH-1:0] core_product;
  logic [2*WIDTH-1:0] signed_prod;

  // Magnitudes kept one bit wider so -2^(WIDTH-1) stays exact.
  always_comb begin
    sign_a      = arg_a[WIDTH-1];
    sign_b      = arg_b[WIDTH-1];
    mag_a       = sign_a ? -{sign_a, arg_a} : {sign_a, arg_a};
    mag_b       = sign_b ? -{sign_b, arg_b} : {sign_b, arg_b};
    arg_err     = CHECK_PARITY &&
                  (parity(64'({arg_a, arg_a_parity})) | parity(64'({arg_b, arg_b_parity})));
    start       = (state == IDLE) && req && !arg_err;
    signed_prod = neg_q ? -core_product : core_product;
  end

  seq_mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mcand_in (mag_a),
    .mplier_in(mag_b),
    .done     (core_done),
    .product  (core_product)
  );

  // Parity failures pass through CALC for one cycle so result_rdy lands right after ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
      neg_q            <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      ack        <= 1'b0;
      result_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ack              <= 1'b1;
            arg_parity_error <= 1'b0;
            neg_q            <= sign_a ^ sign_b;
            err_q            <= arg_err;
            state            <= CALC;
          end
        end
        CALC: begin
          if (err_q) begin
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b1;
            result_rdy       <= 1'b1;
            state            <= DONE;
          end else if (core_done) begin
            result        <= signed_prod;
            result_parity <= parity(64'(signed_prod));
            result_rdy    <= 1'b1;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_par_responder.sv
// Directed bench for mult_par_responder with hand-computed expected products.
module tb_mult_par_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] arg_a;
  logic        arg_a_parity;
  logic [15:0] arg_b;
  logic        arg_b_parity;
  logic        req;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_par_responder #(
    .WIDTH       (16),
    .CHECK_PARITY(1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .arg_a           (arg_a),
    .arg_a_parity    (arg_a_parity),
    .arg_b           (arg_b),
    .arg_b_parity    (arg_b_parity),
    .req             (req),
    .ack             (ack),
    .result          (result),
    .result_parity   (result_parity),
    .result_rdy      (result_rdy),
    .arg_parity_error(arg_parity_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_rdy"}, 64'(result_rdy), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_rpar"}, 64'(result_parity), 64'd0);
    check({tag, "_err"}, 64'(arg_parity_error), 64'd0);
  endtask

  task automatic issue(input string tag, input logic [15:0] a, input logic pa,
                       input logic [15:0] b, input logic pb);
    arg_a        = a;
    arg_a_parity = pa;
    arg_b        = b;
    arg_b_parity = pb;
    req          = 1'b1;
    tick();
    check({tag, "_ack"}, 64'(ack), 64'd1);
    check({tag, "_rdy_in_ack"}, 64'(result_rdy), 64'd0);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp_res, input logic exp_rp,
                             input logic exp_err, input int exp_lat, input bit drop_req);
    int n = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      n = i;
      if (result_rdy === 1'b1) seen = 1'b1;
    end
    check({tag, "_rdy_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_ack_in_rdy"}, 64'(ack), 64'd0);
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_rpar"}, 64'(result_parity), 64'(exp_rp));
    check({tag, "_err"}, 64'(arg_parity_error), 64'(exp_err));
    if (drop_req) req = 1'b0;
    tick();
    check({tag, "_rdy_pulse"}, 64'(result_rdy), 64'd0);
    check({tag, "_ack_after"}, 64'(ack), 64'd0);
    check({tag, "_result_hold"}, 64'(result), 64'(exp_res));
    check({tag, "_err_hold"}, 64'(arg_parity_error), 64'(exp_err));
  endtask

  initial begin
    int rdy_count;
    rst          = 1'b1;
    req          = 1'b0;
    arg_a        = '0;
    arg_a_parity = 1'b0;
    arg_b        = '0;
    arg_b_parity = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 3 * -4 = -12
    issue("neg", 16'h0003, 1'b0, 16'hFFFC, 1'b0);
    wait_result("neg", 32'hFFFF_FFF4, 1'b1, 1'b0, 16, 1'b1);

    // Most negative squared
    issue("minsq", 16'h8000, 1'b1, 16'h8000, 1'b1);
    wait_result("minsq", 32'h4000_0000, 1'b1, 1'b0, 16, 1'b1);

    // -32768 * 32767
    issue("minmax", 16'h8000, 1'b1, 16'h7FFF, 1'b1);
    wait_result("minmax", 32'hC000_8000, 1'b1, 1'b0, 16, 1'b1);

    // Reset 5 cycles after ack aborts the op and clears a non-zero result
    issue("abort", 16'h0005, 1'b0, 16'h0009, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    req = 1'b0;
    rdy_count = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (result_rdy === 1'b1) rdy_count++;
    end
    check("abort_no_rdy", 64'(rdy_count), 64'd0);

    issue("after_rst", 16'h0007, 1'b1, 16'h0006, 1'b0);
    wait_result("after_rst", 32'd42, 1'b1, 1'b0, 16, 1'b1);

    // Bad parity on A, then on B only
    issue("perr_a", 16'h0001, 1'b0, 16'h0002, 1'b1);
    wait_result("perr_a", 32'h0, 1'b0, 1'b1, 1, 1'b1);
    issue("perr_b", 16'h0002, 1'b1, 16'h0003, 1'b1);
    wait_result("perr_b", 32'h0, 1'b0, 1'b1, 1, 1'b0);

    // req held through result_rdy: a new capture two edges after the rdy edge
    issue("b2b1", 16'hFFFF, 1'b0, 16'hFFFF, 1'b0);
    wait_result("b2b1", 32'h0000_0001, 1'b1, 1'b0, 16, 1'b0);
    issue("b2b2", 16'h0000, 1'b0, 16'h1234, 1'b1);
    wait_result("b2b2", 32'h0, 1'b0, 1'b0, 16, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
